// File: rtl/bypass_scoreboard_if.sv
// Pipeline-side bundle for the bypass scoreboard: ID operand requests,
// per-stage result data, pipeline control and the forwarding response.
interface bypass_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
) ();
    localparam int SELW = $clog2(DEPTH + 1);

    logic                      i_id_valid;
    logic [4:0]                i_id_rd;
    logic                      i_id_reg_write;
    logic                      i_id_is_load;
    logic [NUM_SRC*5-1:0]      i_id_rs;
    logic [NUM_SRC*XLEN-1:0]   i_rf_data;
    logic [DEPTH*XLEN-1:0]     i_stage_data;
    logic                      i_hold;
    logic                      i_flush;
    logic [NUM_SRC*XLEN-1:0]   o_operand;
    logic [NUM_SRC*SELW-1:0]   o_fwd_sel;
    logic                      o_stall;
    logic [15:0]               o_stall_count;

    // Pipeline control side: drives requests, consumes forwarding results
    modport master (
        output i_id_valid, i_id_rd, i_id_reg_write, i_id_is_load, i_id_rs,
        output i_rf_data, i_stage_data, i_hold, i_flush,
        input  o_operand, o_fwd_sel, o_stall, o_stall_count
    );

    // Scoreboard side
    modport slave (
        input  i_id_valid, i_id_rd, i_id_reg_write, i_id_is_load, i_id_rs,
        input  i_rf_data, i_stage_data, i_hold, i_flush,
        output o_operand, o_fwd_sel, o_stall, o_stall_count
    );
endinterface

// File: rtl/bypass_scoreboard.sv
// Bypass scoreboard: tracks destination tags of in-flight producers past ID,
// selects the youngest forwardable result per source port, and stalls ID when
// the youngest producer of a source is a load whose data is not yet available.
module bypass_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input logic                 i_clk,
    input logic                 i_rst,
    bypass_scoreboard_if.slave  bus
);
    localparam int SELW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } tag_t;

    tag_t [DEPTH:1]     tag_q, tag_d;
    logic [15:0]        stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0] hazard;
    logic               found;
    logic [4:0]         rs;
    logic               stall;
    logic               push;
    tag_t               id_tag;

    // Per-port youngest-match search; an unready youngest match blocks older ones
    always_comb begin
        hazard        = '0;
        found         = 1'b0;
        rs            = '0;
        bus.o_fwd_sel = '0;
        bus.o_operand = bus.i_rf_data;
        for (int n = 0; n < NUM_SRC; n++) begin
            found = 1'b0;
            rs    = bus.i_id_rs[5*n +: 5];
            for (int k = 1; k <= DEPTH; k++) begin
                if (!found && tag_q[k].valid && (tag_q[k].rd == rs) && (rs != 5'd0)) begin
                    found = 1'b1;
                    if (!tag_q[k].is_load || (k >= LOAD_LAT)) begin
                        bus.o_fwd_sel[SELW*n +: SELW] = SELW'(k);
                        bus.o_operand[XLEN*n +: XLEN] = bus.i_stage_data[XLEN*(k-1) +: XLEN];
                    end else begin
                        hazard[n] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall             = bus.i_id_valid && !bus.i_flush && (|hazard);
    assign bus.o_stall       = stall;
    assign bus.o_stall_count = stall_count_q;

    // Tag shift: push ID on advance, flush squashes both ID and the stage-1 entry
    always_comb begin
        id_tag.valid   = bus.i_id_valid && bus.i_id_reg_write && (bus.i_id_rd != 5'd0);
        id_tag.rd      = bus.i_id_rd;
        id_tag.is_load = bus.i_id_is_load;
        push           = !stall && !bus.i_flush;
        tag_d          = tag_q;
        if (!bus.i_hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                tag_d[k] = (k == 2 && bus.i_flush) ? tag_t'('0) : tag_q[k-1];
            end
            tag_d[1] = push ? id_tag : tag_t'('0);
        end else if (bus.i_flush) begin
            tag_d[1] = '0;
        end
    end

    // Saturating count of cycles in which ID is actually held back by a hazard
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !bus.i_hold && (stall_count_q != 16'hFFFF))
            stall_count_d = stall_count_q + 16'd1;
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_q         <= '0;
            stall_count_q <= '0;
        end else begin
            tag_q         <= tag_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard (XLEN=32, NUM_SRC=2, DEPTH=3, LOAD_LAT=2).
module tb_bypass_scoreboard;
    localparam logic [31:0] S1  = 32'h1111_1111;
    localparam logic [31:0] S2  = 32'h2222_2222;
    localparam logic [31:0] S3  = 32'h3333_3333;
    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0001;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    bypass_scoreboard_if #(.XLEN(32), .NUM_SRC(2), .DEPTH(3)) bus ();

    bypass_scoreboard #(.XLEN(32), .NUM_SRC(2), .DEPTH(3), .LOAD_LAT(2)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                          input logic [4:0] rs0, input logic [4:0] rs1);
        bus.i_id_valid     = v;
        bus.i_id_rd        = rd;
        bus.i_id_reg_write = rw;
        bus.i_id_is_load   = ld;
        bus.i_id_rs        = {rs1, rs0};
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.i_rf_data    = {RF1, RF0};
        bus.i_stage_data = {S3, S2, S1};
        bus.i_hold       = 1'b0;
        bus.i_flush      = 1'b0;
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5);
        #10;
        check("rst_stall", 64'(bus.o_stall), 64'd0);
        check("rst_sel",   64'(bus.o_fwd_sel), 64'd0);
        check("rst_op",    64'(bus.o_operand), {RF1, RF0});
        check("rst_cnt",   64'(bus.o_stall_count), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // ALU x5 then consumer: stage-1 forward, then stage-2
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd10, 1'b0, 1'b0, 5'd5, 5'd0);
        check("alu_sel1",  64'(bus.o_fwd_sel[1:0]), 64'd1);
        check("alu_op1",   64'(bus.o_operand[31:0]), 64'(S1));
        check("alu_stall", 64'(bus.o_stall), 64'd0);
        check("alu_op_p1", 64'(bus.o_operand[63:32]), 64'(RF1));
        tick();
        check("alu_sel2",  64'(bus.o_fwd_sel[1:0]), 64'd2);
        check("alu_op2",   64'(bus.o_operand[31:0]), 64'(S2));
        drain();

        // Load x7 then dependent on port 1: one stall cycle
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        check("ld_stall",  64'(bus.o_stall), 64'd1);
        check("ld_sel0",   64'(bus.o_fwd_sel[3:2]), 64'd0);
        tick();
        check("ld_unstl",  64'(bus.o_stall), 64'd0);
        check("ld_sel2",   64'(bus.o_fwd_sel[3:2]), 64'd2);
        check("ld_op2",    64'(bus.o_operand[63:32]), 64'(S2));
        check("ld_cnt",    64'(bus.o_stall_count), 64'd1);
        drain();

        // x3 at stages 1 and 3, x8 at stage 2: youngest wins
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 5'd8);
        check("yng_sel",   64'(bus.o_fwd_sel), 64'b10_01);
        check("yng_op",    64'(bus.o_operand), {S2, S1});
        drain();

        // Writes to x0 never tracked; rs=x0 never matches
        set_id(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        check("x0_sel",    64'(bus.o_fwd_sel), 64'd0);
        check("x0_stall",  64'(bus.o_stall), 64'd0);
        check("x0_op",     64'(bus.o_operand), {RF1, RF0});
        drain();

        // Load x9 with 3 hold cycles while dependent waits in ID
        set_id(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
        bus.i_hold = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_stall", 64'(bus.o_stall), 64'd1);
            tick();
            check("hold_cnt",   64'(bus.o_stall_count), 64'd1);
        end
        bus.i_hold = 1'b0;
        #1;
        check("hold_rel_stall", 64'(bus.o_stall), 64'd1);
        tick();
        check("hold_done",  64'(bus.o_stall), 64'd0);
        check("hold_sel",   64'(bus.o_fwd_sel[1:0]), 64'd2);
        check("hold_cnt2",  64'(bus.o_stall_count), 64'd2);
        drain();

        // Flush while load x4 sits in stage 1
        set_id(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 5'd0);
        bus.i_flush = 1'b1;
        #1;
        check("fl_stall",   64'(bus.o_stall), 64'd0);
        tick();
        bus.i_flush = 1'b0;
        #1;
        check("fl_cnt",     64'(bus.o_stall_count), 64'd2);
        check("fl_sel",     64'(bus.o_fwd_sel[1:0]), 64'd0);
        check("fl_op",      64'(bus.o_operand[31:0]), 64'(RF0));
        check("fl_stall2",  64'(bus.o_stall), 64'd0);
        drain();

        // Reset asserted mid-stall
        set_id(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        check("mrst_pre",   64'(bus.o_stall), 64'd1);
        i_rst = 1'b1;
        #1;
        check("mrst_stall", 64'(bus.o_stall), 64'd0);
        check("mrst_cnt",   64'(bus.o_stall_count), 64'd0);
        check("mrst_op",    64'(bus.o_operand), {RF1, RF0});
        tick();
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check("mrst_after", 64'(bus.o_fwd_sel), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bypass_scoreboard.md
BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/data width.
REQ-002 SHALL have parameter NUM_SRC, default 2: source operand ports in ID.
REQ-003 SHALL have parameter DEPTH, default 3: tracked producer stages past ID (1 = EX ... DEPTH = WB).
REQ-004 SHALL have parameter LOAD_LAT, default 2: first stage (1..DEPTH) at which load data is forwardable; ALU data is forwardable from stage 1.
REQ-005 SHALL define SELW = clog2(DEPTH+1) locally.
REQ-006 One clock; reset asynchronous, active-high: i_clk input 1 (rising edge), i_rst input 1.
REQ-007 i_id_valid  input  1  ID holds a valid instruction.
REQ-008 i_id_rd  input  5  ID destination register.
REQ-009 i_id_reg_write  input  1  ID instruction writes rd.
REQ-010 i_id_is_load  input  1  ID instruction is a load.
REQ-011 i_id_rs  input  NUM_SRC*5  ID source registers, port n at bits [5n+4:5n].
REQ-012 i_rf_data  input  NUM_SRC*XLEN  register-file read data per port.
REQ-013 i_stage_data  input  DEPTH*XLEN  result currently held in stage k (slice k-1).
REQ-014 i_hold  input  1  global pipeline freeze.
REQ-015 i_flush  input  1  squash stage-1 entry and current ID instruction.
REQ-016 o_operand  output  NUM_SRC*XLEN  bypassed operand per port.
REQ-017 o_fwd_sel  output  NUM_SRC*SELW  0 = register file, k = stage k.
REQ-018 o_stall  output  1  ID must not advance.
REQ-019 o_stall_count  output  16  saturating count of stall cycles.

Function
REQ-020 SHALL keep a DEPTH-entry tag shift register; entry = {valid, rd, is_load}; entry valid only if reg_write=1 and rd != 0.
REQ-021 Advance = !i_hold; on advance entry k moves to k+1, entry DEPTH retires.
REQ-022 On advance, stage 1 loads the ID tag iff i_id_valid && !o_stall && !i_flush; else loads invalid (bubble).
REQ-023 i_flush with i_hold: stage-1 entry invalidated, no shift.
REQ-024 i_hold without flush: all entries unchanged, no push.
REQ-025 Per port n: match = lowest k with valid entry, rd == rs[n], rs[n] != 0; no match -> sel 0, operand = i_rf_data slice n.
REQ-026 Match at k ready if !is_load or k >= LOAD_LAT; ready -> sel k, operand = i_stage_data slice k-1.
REQ-027 Youngest match not ready -> port hazard; older matches SHALL NOT be used; sel 0.
REQ-028 o_stall = i_id_valid && !i_flush && OR of port hazards; combinational, zero latency.
REQ-029 o_fwd_sel, o_operand SHALL be combinational from current tags and inputs.
REQ-030 A load in ID followed by dependent consumer SHALL stall exactly LOAD_LAT-1 cycles (no hold).
REQ-031 o_stall_count SHALL increment on cycles with o_stall && !i_hold; saturates at 16'hFFFF.
REQ-032 rs == 0 SHALL never match or stall, even if a tag carries rd 0.

Reset
REQ-033 i_rst high SHALL immediately invalidate all entries and clear o_stall_count to 0.
REQ-034 During/after reset: o_stall 0, o_fwd_sel 0, o_operand = i_rf_data.
REQ-035 Reset asserted mid-stall SHALL drop o_stall the same cycle; no tag survives.

Verification
REQ-036 ALU x5 issued, next ID reads rs1=x5 -> sel 1, operand = stage-1 data, no stall; next cycle sel 2.
REQ-037 Load x7 (LOAD_LAT=2), next ID rs2=x7 -> o_stall 1 one cycle, then sel 2, count 1.
REQ-038 x3 written at stage 1 and stage 3, ID rs1=x3 -> sel 1 (youngest wins).
REQ-039 rs1=x0 with tags rd 0 present -> sel 0, no stall.
REQ-040 Load x9 then i_hold 3 cycles with dependent in ID -> stall held, count unchanged, resolves 1 cycle after hold drops.
REQ-041 i_flush while load x4 in stage 1 and dependent in ID -> o_stall 0, next cycle no x4 match.
